if_id_buffer: RTL and testbench
===============================

IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 SHALL have parameter INSTR_W, default 32, meaning instruction word width.
REQ-002 SHALL have parameter PC_W, default 32, meaning width of the PC+4 value carried with each instruction.
REQ-003 SHALL have port inp_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port inp_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port inp_valid  input  1  fetch stage offers an instruction this cycle.
REQ-006 SHALL have port inp_instr  input  INSTR_W  fetched instruction word.
REQ-007 SHALL have port inp_pc  input  PC_W  PC+4 of the fetched instruction.
REQ-008 SHALL have port out_ready  output  1  buffer can accept from fetch (not full).
REQ-009 SHALL have port out_valid  output  1  head entry is presented to decode.
REQ-010 SHALL have port out_instr  output  INSTR_W  head instruction.
REQ-011 SHALL have port out_pc  output  PC_W  head PC+4.
REQ-012 SHALL have port inp_ready  input  1  decode accepts the head entry this cycle.
REQ-013 SHALL have port inp_flush  input  1  branch taken; asserted in the same cycle fetch sees inp_pcsrc=1.
REQ-014 SHALL have port out_count  output  2  number of occupied entries (0..2).

Function
REQ-015 SHALL be a 2-entry FIFO (head/tail pointers, 1-bit each, wrap 1->0) of {instr, pc} pairs.
REQ-016 SHALL push on a rising edge when inp_valid=1 and out_ready=1 (push accepted).
REQ-017 SHALL pop on a rising edge when out_valid=1 and inp_ready=1 (pop accepted).
REQ-018 SHALL drive out_ready = (count != 2) and out_valid = (count != 0), both derived from registered state only, with no combinational path from inp_* to out_ready or out_valid.
REQ-019 SHALL present out_instr/out_pc from the head entry when count != 0, and drive all-zeros (NOP) when count == 0.
REQ-020 SHALL have latency 1: an entry pushed at edge N is visible on out_* after edge N, with no same-cycle bypass.
REQ-021 SHALL, on simultaneous push and pop with count=1, leave count at 1, with the head advancing to the new entry.
REQ-022 SHALL, on simultaneous push and pop with count=0, perform no pop (out_valid=0) and take the push, giving count 1.
REQ-023 SHALL never push when count=2, since out_ready=0; inp_valid is ignored in that case.
REQ-024 SHALL give inp_flush priority over push and pop: at that edge count->0, both pointers->0, and the same-cycle push and pop are discarded.
REQ-025 SHALL leave stored data unchanged after a flush; only pointers and count are cleared, and outputs read zero via REQ-019.
REQ-026 SHALL keep count and out_count equal to pushes minus pops since the last reset or flush, saturating by construction at 0..2.

Reset
REQ-027 SHALL, while inp_rst_n=0, immediately (asynchronously) drive count=0, pointers=0, out_valid=0, out_ready=1, out_instr=0, out_pc=0, out_count=0.
REQ-028 SHALL, on reset asserted mid-operation, discard all stored entries, and SHALL accept the first push at the first rising edge after inp_rst_n returns to 1.

Verification
REQ-029 Reset check: assert inp_rst_n=0 between edges -> out_valid=0, out_ready=1, out_count=0, out_instr=0 without waiting for a clock edge.
REQ-030 Fill scenario: push 0x00A00093/pc 0x4 and 0x00B00113/pc 0x8 with inp_ready=0 -> out_count=2, out_ready=0; a third offer 0xDEADBEEF is not stored; out_instr stays 0x00A00093.
REQ-031 Drain scenario: from the full state, inp_ready=1 for 2 cycles -> out_instr 0x00A00093 then 0x00B00113, then out_valid=0 and out_instr=0.
REQ-032 Streaming scenario: count=1, push and pop every cycle for 8 cycles -> out_count stays 1, and each instruction appears exactly once, in order, one cycle after its push.
REQ-033 Flush scenario: count=2, inp_flush=1 together with inp_valid=1 (0x12345678) and inp_ready=1 -> next cycle out_count=0, out_valid=0, 0x12345678 never appears on out_instr.
REQ-034 Empty push/pop scenario: count=0, inp_valid=1 and inp_ready=1 in the same cycle -> no pop occurs, out_count=1 next cycle, and the pushed word appears on out_instr.

Source files
------------

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: a 2-entry FIFO of {instr, pc+4} pairs between fetch and decode.
// Handshake outputs come only from registered state. A flush empties the buffer
// without clearing the stored data, and an empty buffer presents a zero (NOP) word.
module if_id_buffer #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32
) (
  input  logic               inp_clk,
  input  logic               inp_rst_n,
  input  logic               inp_valid,
  input  logic [INSTR_W-1:0] inp_instr,
  input  logic [PC_W-1:0]    inp_pc,
  output logic               out_ready,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               inp_ready,
  input  logic               inp_flush,
  output logic [1:0]         out_count
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  entry_t     mem [2];
  logic       head, tail;
  logic [1:0] count;
  logic       push, pop;
  entry_t     head_e;

  // Handshake is a pure function of the occupancy register.
  assign out_ready = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_count = count;
  assign push      = inp_valid & out_ready;
  assign pop       = out_valid & inp_ready;

  // Pointers and occupancy. A flush wins over any same-cycle push or pop.
  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else if (inp_flush) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) tail <= ~tail;
      if (pop)  head <= ~head;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Entry storage. It is written only on an accepted push and never cleared by a flush.
  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else if (push && !inp_flush) begin
      mem[tail] <= '{instr: inp_instr, pc: inp_pc};
    end
  end

  // Present the head entry, or a zero NOP when the buffer is empty.
  always_comb begin
    head_e    = mem[head];
    out_instr = '0;
    out_pc    = '0;
    if (out_valid) begin
      out_instr = head_e.instr;
      out_pc    = head_e.pc;
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Randomised and directed bench for if_id_buffer. A queue-based reference FIFO holds the
// expected contents, and a negedge monitor compares the DUT outputs against the queue head.
module tb_if_id_buffer;
  localparam int IW = 32;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_i, ready_i, flush_i;
  logic [IW-1:0] instr_i;
  logic [PW-1:0] pc_i;
  logic          ready_o, valid_o;
  logic [IW-1:0] instr_o;
  logic [PW-1:0] pc_o;
  logic [1:0]    count_o;

  int vectors    = 0;
  int miscompares = 0;
  logic [IW+PW-1:0] exp_q [$];

  if_id_buffer #(.INSTR_W(IW), .PC_W(PW)) dut (
    .inp_clk(clk), .inp_rst_n(rst_n), .inp_valid(valid_i), .inp_instr(instr_i),
    .inp_pc(pc_i), .out_ready(ready_o), .out_valid(valid_o), .out_instr(instr_o),
    .out_pc(pc_o), .inp_ready(ready_i), .inp_flush(flush_i), .out_count(count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, let the edge happen, and then advance the reference FIFO.
  task automatic drive(input logic v, input logic [IW-1:0] ins, input logic [PW-1:0] pc,
                       input logic r, input logic f);
    int sz;
    bit dpush, dpop;
    valid_i = v; instr_i = ins; pc_i = pc; ready_i = r; flush_i = f;
    sz = exp_q.size();
    @(posedge clk); #1;
    if (f) exp_q.delete();
    else begin
      dpop  = r && (sz > 0);
      dpush = v && (sz < 2);
      if (dpop)  void'(exp_q.pop_front());
      if (dpush) exp_q.push_back({ins, pc});
    end
    valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
  endtask

  // Monitor: compare the visible head and the handshake signals against the reference.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("count", 64'(count_o), 64'(exp_q.size()));
      chk("valid", 64'(valid_o), 64'(exp_q.size() != 0));
      chk("ready", 64'(ready_o), 64'(exp_q.size() != 2));
      if (exp_q.size() != 0) begin
        chk("instr", 64'(instr_o), 64'(exp_q[0][IW+PW-1:PW]));
        chk("pc",    64'(pc_o),    64'(exp_q[0][PW-1:0]));
      end else begin
        chk("nop_instr", 64'(instr_o), 64'd0);
        chk("nop_pc",    64'(pc_o),    64'd0);
      end
    end
  end

  initial begin
    rst_n = 1'b0; valid_i = 0; ready_i = 0; flush_i = 0; instr_i = '0; pc_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_count", 64'(count_o), 64'd0);
    rst_n = 1'b1;

    // Fill: two entries are stored, and the third offer is refused.
    drive(1, 32'h00A00093, 32'h4, 0, 0);
    drive(1, 32'h00B00113, 32'h8, 0, 0);
    drive(1, 32'hDEADBEEF, 32'hC, 0, 0);
    chk("fill_count", 64'(count_o), 64'd2);
    chk("fill_ready", 64'(ready_o), 64'd0);
    chk("fill_head",  64'(instr_o), 64'h00A00093);

    // Drain
    drive(0, '0, '0, 1, 0);
    chk("drain1", 64'(instr_o), 64'h00B00113);
    drive(0, '0, '0, 1, 0);
    chk("drain_valid", 64'(valid_o), 64'd0);
    chk("drain_instr", 64'(instr_o), 64'd0);

    // Streaming at a steady occupancy of one
    drive(1, 32'h10000013, 32'h100, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      drive(1, 32'h10000013 + 32'(i), 32'h100 + 32'(4*i), 1, 0);
      chk("stream_count", 64'(count_o), 64'd1);
      chk("stream_head",  64'(instr_o), 64'(32'h10000013 + 32'(i)));
    end

    // Flush from full: the same-cycle push and pop are both discarded.
    drive(1, 32'h20000013, 32'h200, 0, 0);
    drive(1, 32'h12345678, 32'h204, 1, 1);
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_valid", 64'(valid_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, '0, 1, 0);
      chk("flush_ghost", 64'(instr_o == 32'h12345678), 64'd0);
    end

    // Push and pop together while empty: only the push takes effect.
    drive(1, 32'hCAFE0013, 32'h300, 1, 0);
    chk("empty_pp_count", 64'(count_o), 64'd1);
    chk("empty_pp_instr", 64'(instr_o), 64'hCAFE0013);

    // Reset mid-operation, checked between edges without waiting for a clock.
    drive(1, 32'hBEEF0013, 32'h304, 0, 0);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_valid", 64'(valid_o), 64'd0);
    chk("arst_ready", 64'(ready_o), 64'd1);
    chk("arst_count", 64'(count_o), 64'd0);
    chk("arst_instr", 64'(instr_o), 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    drive(1, 32'h0F0F0013, 32'h400, 0, 0);
    chk("post_rst_push", 64'(instr_o), 64'h0F0F0013);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
